// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - hazard and stall sequencer for the 5-stage MIPS pipeline
module pipeline_hazard_controller #(
  parameter int N_REG_ADDR  = 5,
  parameter int N_CNT       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  id_valid_i,
  input  logic [N_REG_ADDR-1:0] id_rs_i,
  input  logic [N_REG_ADDR-1:0] id_rt_i,
  input  logic                  ex_mem_read_i,
  input  logic [N_REG_ADDR-1:0] ex_rt_i,
  input  logic                  mem_branch_taken_i,
  input  logic                  mem_access_i,
  input  logic                  dmem_ready_i,
  output logic                  pc_write_o,
  output logic                  ifid_write_o,
  output logic                  ctrl_sel_o,
  output logic                  ifid_flush_o,
  output logic                  idex_flush_o,
  output logic                  exmem_flush_o,
  output logic                  pipe_hold_o,
  output logic                  mem_error_o,
  output logic [N_CNT-1:0]      stall_count_o,
  output logic [N_CNT-1:0]      flush_count_o
);

  // Wide enough to hold MEM_TIMEOUT itself.
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] TIMEOUT_W = WW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    ERROR    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic            pend_q, pend_d;
  logic [N_CNT-1:0] stall_q, flush_q;
  logic            stall_inc, flush_inc;

  logic load_use;
  logic mem_wait;
  logic branch;

  assign load_use = id_valid_i & ex_mem_read_i & (|ex_rt_i) &
                    ((ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i));
  assign mem_wait = mem_access_i & ~dmem_ready_i;
  // A branch seen while the pipe was frozen is replayed once the hold lifts.
  assign branch   = mem_branch_taken_i | pend_q;

  assign stall_count_o = stall_q;
  assign flush_count_o = flush_q;

  // Next-state and control outputs from state and the current stage fields.
  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ctrl_sel_o    = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_flush_o  = 1'b0;
    exmem_flush_o = 1'b0;
    pipe_hold_o   = 1'b0;
    mem_error_o   = 1'b0;
    state_d       = state_q;
    wait_d        = wait_q;
    pend_d        = pend_q;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;

    case (state_q)
      RUN, LU_STALL: begin
        if (mem_wait) begin
          pipe_hold_o  = 1'b1;
          pc_write_o   = 1'b0;
          ifid_write_o = 1'b0;
          stall_inc    = 1'b1;
          pend_d       = pend_q | mem_branch_taken_i;
          wait_d       = WW'(1);
          state_d      = (TIMEOUT_W == WW'(1)) ? ERROR : MEM_WAIT;
        end else if (branch) begin
          ctrl_sel_o    = 1'b1;
          ifid_flush_o  = 1'b1;
          idex_flush_o  = 1'b1;
          exmem_flush_o = 1'b1;
          flush_inc     = 1'b1;
          pend_d        = 1'b0;
          state_d       = RUN;
        end else if (load_use && (state_q == RUN)) begin
          pc_write_o   = 1'b0;
          ifid_write_o = 1'b0;
          ctrl_sel_o   = 1'b1;
          stall_inc    = 1'b1;
          state_d      = LU_STALL;
        end else begin
          state_d = RUN;
        end
      end
      MEM_WAIT: begin
        pend_d = pend_q | mem_branch_taken_i;
        if (dmem_ready_i) begin
          wait_d  = '0;
          state_d = RUN;
        end else begin
          pipe_hold_o  = 1'b1;
          pc_write_o   = 1'b0;
          ifid_write_o = 1'b0;
          stall_inc    = 1'b1;
          wait_d       = wait_q + WW'(1);
          if (wait_q + WW'(1) == TIMEOUT_W) begin
            state_d = ERROR;
          end
        end
      end
      ERROR: begin
        pipe_hold_o  = 1'b1;
        pc_write_o   = 1'b0;
        ifid_write_o = 1'b0;
        ctrl_sel_o   = 1'b1;
        mem_error_o  = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (!reset_i) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      ctrl_sel_o    = 1'b1;
      ifid_flush_o  = 1'b1;
      idex_flush_o  = 1'b1;
      exmem_flush_o = 1'b1;
      pipe_hold_o   = 1'b0;
      mem_error_o   = 1'b0;
    end
  end

  // State, wait counter, deferred branch and saturating event counters.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= RUN;
      wait_q  <= '0;
      pend_q  <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      pend_q  <= pend_d;
      if (stall_inc && (stall_q != {N_CNT{1'b1}})) begin
        stall_q <= stall_q + N_CNT'(1);
      end
      if (flush_inc && (flush_q != {N_CNT{1'b1}})) begin
        flush_q <= flush_q + N_CNT'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb/tb_pipeline_hazard_controller.sv - scoreboard bench for pipeline_hazard_controller
module tb_pipeline_hazard_controller;
  localparam int NR   = 5;
  localparam int NC   = 2;
  localparam int TO   = 4;
  localparam int CMAX = (1 << NC) - 1;

  // {pc_write, ifid_write, ctrl_sel, ifid_flush, idex_flush, exmem_flush, pipe_hold, mem_error}
  localparam logic [7:0] C_DEF  = 8'b1100_0000;
  localparam logic [7:0] C_HOLD = 8'b0000_0010;
  localparam logic [7:0] C_ERR  = 8'b0010_0011;
  localparam logic [7:0] C_BR   = 8'b1111_1100;
  localparam logic [7:0] C_LU   = 8'b0010_0000;
  localparam logic [7:0] C_RST  = 8'b0011_1100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          id_valid;
  logic [NR-1:0] id_rs, id_rt, ex_rt;
  logic          ex_mem_read, br_taken, mem_access, dmem_ready;
  logic          pc_write, ifid_write, ctrl_sel, ifid_flush, idex_flush, exmem_flush;
  logic          pipe_hold, mem_error;
  logic [NC-1:0] stall_count, flush_count;

  pipeline_hazard_controller #(
    .N_REG_ADDR (NR),
    .N_CNT      (NC),
    .MEM_TIMEOUT(TO)
  ) dut (
    .clk_i             (clk),
    .reset_i           (reset_n),
    .id_valid_i        (id_valid),
    .id_rs_i           (id_rs),
    .id_rt_i           (id_rt),
    .ex_mem_read_i     (ex_mem_read),
    .ex_rt_i           (ex_rt),
    .mem_branch_taken_i(br_taken),
    .mem_access_i      (mem_access),
    .dmem_ready_i      (dmem_ready),
    .pc_write_o        (pc_write),
    .ifid_write_o      (ifid_write),
    .ctrl_sel_o        (ctrl_sel),
    .ifid_flush_o      (ifid_flush),
    .idex_flush_o      (idex_flush),
    .exmem_flush_o     (exmem_flush),
    .pipe_hold_o       (pipe_hold),
    .mem_error_o       (mem_error),
    .stall_count_o     (stall_count),
    .flush_count_o     (flush_count)
  );

  typedef struct packed {
    logic [7:0]    ctl;
    logic [NC-1:0] sc;
    logic [NC-1:0] fc;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;
  int mon_cyc = 0;

  // Reference model: what the pipeline has experienced so far.
  bit m_err;      // timed out, waiting for reset
  bit m_just_lu;  // previous cycle inserted the load-use bubble
  bit m_pend;     // branch seen while frozen, not yet flushed
  int m_held;     // consecutive frozen cycles of the current memory access
  int m_st, m_fl; // event totals

  function automatic int sat(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  task automatic drive(input bit rst, input bit idv, input logic [NR-1:0] rs,
                       input logic [NR-1:0] rt, input bit mr, input logic [NR-1:0] ert,
                       input bit br, input bit acc, input bit rdy);
    exp_t e;
    @(posedge clk);
    #1;
    reset_n = rst; id_valid = idv; id_rs = rs; id_rt = rt; ex_mem_read = mr;
    ex_rt = ert; br_taken = br; mem_access = acc; dmem_ready = rdy;
    e.sc = NC'(m_st);
    e.fc = NC'(m_fl);
    if (!rst) begin
      e.ctl = C_RST;
      m_err = 0; m_just_lu = 0; m_pend = 0; m_held = 0; m_st = 0; m_fl = 0;
    end else if (m_err) begin
      e.ctl = C_ERR;
    end else if (m_held > 0) begin
      m_pend = m_pend | br;
      if (rdy) begin
        e.ctl = C_DEF;
        m_held = 0;
      end else begin
        e.ctl = C_HOLD;
        m_st = sat(m_st);
        m_held++;
        if (m_held == TO) m_err = 1;
      end
    end else if (acc && !rdy) begin
      e.ctl = C_HOLD;
      m_st = sat(m_st);
      m_pend = m_pend | br;
      m_held = 1;
      m_just_lu = 0;
      if (m_held == TO) m_err = 1;
    end else if (br || m_pend) begin
      e.ctl = C_BR;
      m_fl = sat(m_fl);
      m_pend = 0;
      m_just_lu = 0;
    end else if (!m_just_lu && idv && mr && ert != 0 && (ert == rs || ert == rt)) begin
      e.ctl = C_LU;
      m_st = sat(m_st);
      m_just_lu = 1;
    end else begin
      e.ctl = C_DEF;
      m_just_lu = 0;
    end
    q.push_back(e);
  endtask

  task automatic idle();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic lu();
    drive(1, 1, 5, 0, 1, 5, 0, 0, 1);
  endtask

  // Monitor: every cycle the DUT presents a full control word; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      mon_cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if ({pc_write, ifid_write, ctrl_sel, ifid_flush, idex_flush, exmem_flush,
             pipe_hold, mem_error} !== e.ctl || stall_count !== e.sc || flush_count !== e.fc) begin
          bad++;
          $display("FAIL cyc=%0d ctl/stall/flush got=%b/%0d/%0d exp=%b/%0d/%0d", mon_cyc,
                   {pc_write, ifid_write, ctrl_sel, ifid_flush, idex_flush, exmem_flush,
                    pipe_hold, mem_error}, stall_count, flush_count, e.ctl, e.sc, e.fc);
        end
      end
    end
  end

  initial begin
    reset_n = 0; id_valid = 0; id_rs = 0; id_rt = 0; ex_mem_read = 0; ex_rt = 0;
    br_taken = 0; mem_access = 0; dmem_ready = 1;
    m_err = 0; m_just_lu = 0; m_pend = 0; m_held = 0; m_st = 0; m_fl = 0;

    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    // load-use with one bubble, then ex_rt == 0 never stalls
    lu(); lu(); idle();
    drive(1, 1, 0, 0, 1, 0, 0, 0, 1);
    // taken branch, then branch together with load-use after a reset
    drive(1, 0, 0, 0, 0, 0, 1, 0, 1); idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 1, 5, 0, 1, 5, 1, 0, 1); idle();
    // three wait cycles then ready
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 1); idle();
    // branch during a hold flushes only after release
    drive(1, 0, 0, 0, 0, 0, 1, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 1, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(); idle();
    // timeout into ERROR, then one reset cycle
    for (int i = 0; i < 7; i++) drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(); idle();
    // five load-use stalls saturate the 2-bit counter
    for (int i = 0; i < 5; i++) begin lu(); lu(); end
    idle();
    // reset while in LU_STALL
    lu();
    drive(0, 1, 5, 0, 1, 5, 0, 0, 1);
    idle(); idle();
    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom % 60) != 0, ($urandom % 4) != 0, NR'($urandom % 4), NR'($urandom % 4),
            $urandom % 2, NR'($urandom % 4), ($urandom % 8) == 0, ($urandom % 4) == 0,
            $urandom % 2);
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d need=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Hazard and stall sequencer for the 5-stage MIPS pipeline. It watches the IF/ID, ID/EX and EX/MEM stage fields and the data-memory handshake. It drives the PC write enable, the IF/ID write enable, the control-bubble select that zeroes the ID/EX control bundle, the per-stage flushes and a global pipeline hold. It resolves load-use stalls, taken-branch flushes and data-memory wait states, detects memory timeouts, and keeps saturating stall/flush event counters.

## Interface
- N_REG_ADDR, 5, register-address width
- N_CNT, 16, width of the stall and flush counters
- MEM_TIMEOUT, 64, cycles spent in MEM_WAIT before declaring a memory error
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- id_valid  in  1  IF/ID holds a real instruction
- id_rs, id_rt  in  N_REG_ADDR  source fields of the instruction in IF/ID
- ex_mem_read  in  1  ID/EX instruction is a load
- ex_rt  in  N_REG_ADDR  load destination in ID/EX
- mem_branch_taken  in  1  EX/MEM branch & zero (branch resolved in MEM)
- mem_access  in  1  EX/MEM mem_read | mem_write
- dmem_ready  in  1  data memory completes the access this cycle
- pc_write  out  1  PC register load enable
- ifid_write  out  1  IF/ID load enable
- ctrl_sel  out  1  1 = select all-zero control bundle into ID/EX (bubble)
- ifid_flush, idex_flush, exmem_flush  out  1  clear the stage register at next edge
- pipe_hold  out  1  freeze every stage register, including MEM/WB
- mem_error  out  1  sticky memory-timeout flag
- stall_count, flush_count  out  N_CNT  saturating event counters

## Operation
- States: RUN, LU_STALL, MEM_WAIT, ERROR. State register and counters are updated on the clock edge. Control outputs are combinational from state and inputs.
- Priority in RUN, highest first: memory wait, taken branch, load-use.
- Memory wait condition: mem_access & !dmem_ready.
  - Outputs: pipe_hold=1, pc_write=0, ifid_write=0, ctrl_sel=0, no flushes.
  - Next state: MEM_WAIT.
- Taken branch (mem_branch_taken, no memory wait):
  - Outputs: pc_write=1 (target loads), ifid_flush=idex_flush=exmem_flush=1, ctrl_sel=1.
  - Effects: flush_count += 1; next state RUN.
- Load-use condition: id_valid & ex_mem_read & ex_rt≠0 & (ex_rt==id_rs | ex_rt==id_rt).
  - Outputs: pc_write=0, ifid_write=0, ctrl_sel=1.
  - Effects: stall_count += 1; next state LU_STALL.
- Default (no hazard): pc_write=1, ifid_write=1, all other controls 0.
- LU_STALL:
  - Load-use detection is suppressed.
  - Branch and memory-wait rules apply exactly as in RUN.
  - Otherwise default outputs; next state RUN.
- MEM_WAIT:
  - Internal wait counter increments each cycle.
  - pipe_hold=1 while !dmem_ready. stall_count += 1 per held cycle.
  - When dmem_ready=1, hold releases combinationally that cycle with default outputs, and next state is RUN.
  - A taken branch sitting in EX/MEM during a hold is deferred, not lost.
  - When the wait counter reaches MEM_TIMEOUT, next state is ERROR.
- ERROR: pipe_hold=1, pc_write=0, ifid_write=0, ctrl_sel=1, mem_error=1. The block stays in ERROR until reset.
- Counters: saturate at all-ones; they never wrap.

## Timing
- While reset=0, outputs are forced: pc_write=0, ifid_write=0, ctrl_sel=1, all three flushes=1, pipe_hold=0, mem_error=0.
- First clock edge with reset=0 sets: state=RUN, wait counter=0, stall_count=0, flush_count=0, mem_error=0.
- Reset asserted mid-stall or in ERROR: recovery to RUN at the same edge.
- Load-use: exactly one bubble.
  - Stall asserts in cycle T.
  - Bubble occupies EX in T+1.
  - T+1 outputs are default unless another hazard is present.
- Branch: flushes asserted for exactly the one cycle mem_branch_taken is seen outside a hold. That gives three squashed instructions.
- MEM_WAIT: hold asserts in the same cycle the access is seen not-ready. Release takes zero extra cycles after dmem_ready.
- Timeout: ERROR is entered at the edge ending wait cycle MEM_TIMEOUT. mem_error is visible in the next cycle.

## Test plan
- Load-use:
  - Stimulus: id_valid=1, ex_mem_read=1, ex_rt=5, id_rs=5.
  - Expected in cycle T: pc_write=0, ifid_write=0, ctrl_sel=1.
  - Expected in T+1 (inputs unchanged): default outputs; stall_count=1.
  - With ex_rt=0: no stall.
- Taken branch:
  - Stimulus: mem_branch_taken=1 for one cycle.
  - Expected: all three flushes=1, ctrl_sel=1, pc_write=1; flush_count=1.
  - With the load-use condition also true: the branch wins and stall_count stays 0.
- Memory wait:
  - Stimulus: mem_access=1, dmem_ready=0 for 3 cycles, then 1.
  - Expected: pipe_hold=1 for 3 cycles and 0 in the ready cycle; stall_count=3.
  - A branch asserted during the hold produces its flush only after release.
- Timeout:
  - Stimulus: MEM_TIMEOUT=4, dmem_ready held 0.
  - Expected: mem_error=1 from cycle 5 onward, pipe_hold stuck at 1.
  - Then drive reset=0 for 1 cycle: outputs return to default, counters and mem_error read 0.
- Saturation:
  - Stimulus: N_CNT=2, 5 load-use stalls.
  - Expected: stall_count=3.
- Reset during LU_STALL:
  - Stimulus: drive reset=0 while in LU_STALL.
  - Expected: forced reset outputs while reset is low, then RUN defaults.
